snake_body_tracker: RTL and testbench

SNAKE_BODY_TRACKER -- requirements
Module: snake_body_tracker

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_next_head.sv | 41 ++++
 rtl/snake_body_tracker.sv | 167 ++++++++++++++++
 tb/tb_snake_body_tracker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared constants for the snake body tracker: default playfield size,
//   the empty-slot marker, direction encodings and the FSM state encoding.
//   No ports; imported by snake_next_head and snake_body_tracker.

package snake_pkg;

    localparam int GRID_W_DEFAULT = 10;
    localparam int GRID_H_DEFAULT = 10;

    // Unused body slots read back as all-ones in both coordinates.
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_MOVE = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Opposite directions differ only in bit 1 (up<->down, right<->left).
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// snake_next_head
//   Combinational next-head calculation.
//   Ports:
//     head_x, head_y   current head tile (slot 0)
//     cur_dir          direction currently being travelled
//     req_dir          direction requested on this tick
//     eff_dir          direction actually taken (a reversal request is ignored)
//     next_x, next_y   head tile after one step in eff_dir (32-bit unsigned)
//     out_of_bounds    next head lies outside GRID_W x GRID_H

module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEFAULT,
    parameter int GRID_H = GRID_H_DEFAULT
) (
    input  logic [31:0] head_x,
    input  logic [31:0] head_y,
    input  logic [1:0]  cur_dir,
    input  logic [1:0]  req_dir,
    output logic [1:0]  eff_dir,
    output logic [31:0] next_x,
    output logic [31:0] next_y,
    output logic        out_of_bounds
);

    always_comb begin
        eff_dir = (req_dir == reverse_dir(cur_dir)) ? cur_dir : req_dir;
        next_x  = head_x;
        next_y  = head_y;
        case (eff_dir)
            DIR_UP:    next_y = head_y - 32'd1;
            DIR_RIGHT: next_x = head_x + 32'd1;
            DIR_DOWN:  next_y = head_y + 32'd1;
            DIR_LEFT:  next_x = head_x - 32'd1;
        endcase
        // Stepping below 0 wraps to 32'hFFFFFFFF, which this compare also catches.
        out_of_bounds = (next_x >= 32'(GRID_W)) || (next_y >= 32'(GRID_H));
    end

endmodule

// File: rtl/snake_body_tracker.sv
// snake_body_tracker
//   Tracks the snake body on a GRID_W x GRID_H playfield. A tick starts a
//   move: the next head is bounds-checked, then compared against one body
//   slot per cycle (SCAN), then the body is shifted in a single MOVE cycle.
//   Ports:
//     clk, reset         clock, synchronous active-high reset
//     tick, dir          move strobe and requested direction (0 up,1 right,2 down,3 left)
//     food_x, food_y     food tile, sampled with tick
//     x_values, y_values slot k at [32k+:32], slot 0 is the head, unused = all ones
//     score              food eaten since reset
//     ate                one-cycle pulse when food is consumed
//     busy               move in progress; ticks are dropped
//     game_done          sticky game-over flag
//     fsm_state          current FSM state (ST_* encoding) for observation

module snake_body_tracker
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEFAULT,
    parameter int GRID_H   = GRID_H_DEFAULT,
    parameter int MAX_LEN  = 100,
    parameter int INIT_LEN = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [1:0]              dir,
    input  logic [31:0]             food_x,
    input  logic [31:0]             food_y,
    output logic [MAX_LEN*32-1:0]   x_values,
    output logic [MAX_LEN*32-1:0]   y_values,
    output logic [31:0]             score,
    output logic                    ate,
    output logic                    busy,
    output logic                    game_done,
    output logic [1:0]              fsm_state
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [1:0]       state;
    logic [1:0]       cur_dir;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] scan_idx;
    logic [31:0]      body_x [MAX_LEN];
    logic [31:0]      body_y [MAX_LEN];
    logic [31:0]      tgt_x;
    logic [31:0]      tgt_y;
    logic             grow;

    logic [1:0]  eff_dir;
    logic [31:0] next_x;
    logic [31:0] next_y;
    logic        out_of_bounds;

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_next_head (
        .head_x        (body_x[0]),
        .head_y        (body_y[0]),
        .cur_dir       (cur_dir),
        .req_dir       (dir),
        .eff_dir       (eff_dir),
        .next_x        (next_x),
        .next_y        (next_y),
        .out_of_bounds (out_of_bounds)
    );

    logic last_scan;
    logic slot_hit;

    always_comb begin
        last_scan = (scan_idx == len - LEN_W'(1));
        // Without growth the tail vacates its tile during this move, so the
        // last slot cannot be collided with.
        slot_hit  = (body_x[IDX_W'(scan_idx)] == tgt_x) &&
                    (body_y[IDX_W'(scan_idx)] == tgt_y) &&
                    !(last_scan && !grow);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cur_dir  <= DIR_RIGHT;
            len      <= LEN_W'(INIT_LEN);
            scan_idx <= '0;
            tgt_x    <= '0;
            tgt_y    <= '0;
            grow     <= 1'b0;
            score    <= '0;
            ate      <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                if (k < INIT_LEN) begin
                    body_x[k] <= 32'(GRID_W / 2) - 32'(k);
                    body_y[k] <= 32'(GRID_H / 2);
                end else begin
                    body_x[k] <= EMPTY;
                    body_y[k] <= EMPTY;
                end
            end
        end else begin
            ate <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        cur_dir  <= eff_dir;
                        tgt_x    <= next_x;
                        tgt_y    <= next_y;
                        grow     <= (next_x == food_x) && (next_y == food_y);
                        scan_idx <= '0;
                        state    <= out_of_bounds ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (slot_hit) begin
                        state <= ST_DONE;
                    end else if (last_scan) begin
                        state <= ST_MOVE;
                    end else begin
                        scan_idx <= scan_idx + LEN_W'(1);
                    end
                end
                ST_MOVE: begin
                    if (grow && (len == LEN_W'(MAX_LEN))) begin
                        // No room to grow: the game ends with the body untouched.
                        state <= ST_DONE;
                    end else begin
                        for (int k = MAX_LEN - 1; k >= 1; k--) begin
                            body_x[k] <= body_x[k-1];
                            body_y[k] <= body_y[k-1];
                        end
                        body_x[0] <= tgt_x;
                        body_y[0] <= tgt_y;
                        if (grow) begin
                            len   <= len + LEN_W'(1);
                            score <= score + 32'd1;
                            ate   <= 1'b1;
                        end else if (len < LEN_W'(MAX_LEN)) begin
                            // Overrides the shifted-in old tail.
                            body_x[IDX_W'(len)] <= EMPTY;
                            body_y[IDX_W'(len)] <= EMPTY;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
        assign x_values[32*g +: 32] = body_x[g];
        assign y_values[32*g +: 32] = body_y[g];
    end

    assign busy      = (state == ST_SCAN) || (state == ST_MOVE);
    assign game_done = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_snake_body_tracker.sv
// tb_snake_body_tracker
//   Directed bench for snake_body_tracker on a 10x10 grid with MAX_LEN=5.
//   A table of moves (optional reset, tick inputs, expected body, score,
//   ate pulses, edges until idle, game_done) plus hand-written sequences
//   for tick-while-busy and reset during SCAN.

module tb_snake_body_tracker;
    import snake_pkg::*;

    localparam int NSLOT = 5;
    localparam int NV    = 20;
    localparam logic [31:0] E = 32'hFFFF_FFFF;

    logic                  clk;
    logic                  reset;
    logic                  tick;
    logic [1:0]            dir;
    logic [31:0]           food_x;
    logic [31:0]           food_y;
    logic [NSLOT*32-1:0]   x_values;
    logic [NSLOT*32-1:0]   y_values;
    logic [31:0]           score;
    logic                  ate;
    logic                  busy;
    logic                  game_done;
    logic [1:0]            fsm_state;

    snake_body_tracker #(
        .GRID_W   (10),
        .GRID_H   (10),
        .MAX_LEN  (NSLOT),
        .INIT_LEN (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .dir       (dir),
        .food_x    (food_x),
        .food_y    (food_y),
        .x_values  (x_values),
        .y_values  (y_values),
        .score     (score),
        .ate       (ate),
        .busy      (busy),
        .game_done (game_done),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks;
    int passed_checks;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        tick  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] slot_x(input int k);
        return x_values[32*k +: 32];
    endfunction

    function automatic logic [31:0] slot_y(input int k);
        return y_values[32*k +: 32];
    endfunction

    // ---------------- vector table ----------------
    // ex/ey list slots high to low in the concatenations below: {s4,s3,s2,s1,s0}.
    typedef struct packed {
        logic                 rst;
        logic [1:0]           d;
        logic [31:0]          fx;
        logic [31:0]          fy;
        logic [4:0][31:0]     ex;
        logic [4:0][31:0]     ey;
        logic [31:0]          sc;
        logic [31:0]          ate_n;
        logic [31:0]          edges;
        logic                 done;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic [1:0] d,
                                input logic [31:0] fx, input logic [31:0] fy,
                                input logic [4:0][31:0] ex, input logic [4:0][31:0] ey,
                                input logic [31:0] sc, input logic [31:0] an,
                                input logic [31:0] ed, input logic dn);
        vec_t v;
        v.rst = rst; v.d = d; v.fx = fx; v.fy = fy; v.ex = ex; v.ey = ey;
        v.sc = sc; v.ate_n = an; v.edges = ed; v.done = dn;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic pulse_tick(input logic [1:0] d, input logic [31:0] fx, input logic [31:0] fy);
        @(negedge clk);
        tick   = 1'b1;
        dir    = d;
        food_x = fx;
        food_y = fy;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Waits (bounded) for busy to drop; returns edges since the tick edge and ate pulses seen.
    task automatic wait_idle(output int edges, output int ate_cnt);
        edges   = 1;
        ate_cnt = int'(ate);
        while (busy && edges < 60) begin
            @(negedge clk);
            edges++;
            ate_cnt += int'(ate);
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
        ate_cnt += int'(ate);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   edges;
        int   ate_cnt;
        v = vecs[i];
        if (v.rst) apply_reset();
        pulse_tick(v.d, v.fx, v.fy);
        wait_idle(edges, ate_cnt);
        for (int k = 0; k < NSLOT; k++) begin
            chk($sformatf("v%0d slot%0d x", i, k), slot_x(k), v.ex[k]);
            chk($sformatf("v%0d slot%0d y", i, k), slot_y(k), v.ey[k]);
        end
        chk($sformatf("v%0d score", i), score, v.sc);
        chk($sformatf("v%0d ate pulses", i), 32'(ate_cnt), v.ate_n);
        chk($sformatf("v%0d edges", i), 32'(edges), v.edges);
        chk($sformatf("v%0d game_done", i), 32'(game_done), 32'(v.done));
    endtask

    // ---------------- test ----------------
    initial begin
        int edges;
        int ate_cnt;
        total_checks  = 0;
        passed_checks = 0;
        reset  = 1'b1;
        tick   = 1'b0;
        dir    = 2'd1;
        food_x = 32'd9;
        food_y = 32'd9;

        vecs[0]  = mk(1'b1, 2'd1, 32'd9, 32'd9, {E, E, E, 32'd5, 32'd6}, {E, E, E, 32'd5, 32'd5}, 32'd0, 32'd0, 32'd4, 1'b0);
        vecs[1]  = mk(1'b1, 2'd1, 32'd6, 32'd5, {E, E, 32'd4, 32'd5, 32'd6}, {E, E, 32'd5, 32'd5, 32'd5}, 32'd1, 32'd1, 32'd4, 1'b0);
        vecs[2]  = mk(1'b0, 2'd3, 32'd7, 32'd5, {E, 32'd4, 32'd5, 32'd6, 32'd7}, {E, 32'd5, 32'd5, 32'd5, 32'd5}, 32'd2, 32'd1, 32'd5, 1'b0);
        vecs[3]  = mk(1'b0, 2'd1, 32'd8, 32'd5, {32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, {32'd5, 32'd5, 32'd5, 32'd5, 32'd5}, 32'd3, 32'd1, 32'd6, 1'b0);
        vecs[4]  = mk(1'b0, 2'd2, 32'd0, 32'd0, {32'd5, 32'd6, 32'd7, 32'd8, 32'd8}, {32'd5, 32'd5, 32'd5, 32'd5, 32'd6}, 32'd3, 32'd0, 32'd7, 1'b0);
        vecs[5]  = mk(1'b0, 2'd3, 32'd0, 32'd0, {32'd6, 32'd7, 32'd8, 32'd8, 32'd7}, {32'd5, 32'd5, 32'd5, 32'd6, 32'd6}, 32'd3, 32'd0, 32'd7, 1'b0);
        vecs[6]  = mk(1'b0, 2'd0, 32'd0, 32'd0, {32'd6, 32'd7, 32'd8, 32'd8, 32'd7}, {32'd5, 32'd5, 32'd5, 32'd6, 32'd6}, 32'd3, 32'd0, 32'd5, 1'b1);
        vecs[7]  = mk(1'b0, 2'd1, 32'd0, 32'd0, {32'd6, 32'd7, 32'd8, 32'd8, 32'd7}, {32'd5, 32'd5, 32'd5, 32'd6, 32'd6}, 32'd3, 32'd0, 32'd1, 1'b1);
        vecs[8]  = mk(1'b1, 2'd1, 32'd6, 32'd5, {E, E, 32'd4, 32'd5, 32'd6}, {E, E, 32'd5, 32'd5, 32'd5}, 32'd1, 32'd1, 32'd4, 1'b0);
        vecs[9]  = mk(1'b0, 2'd1, 32'd7, 32'd5, {E, 32'd4, 32'd5, 32'd6, 32'd7}, {E, 32'd5, 32'd5, 32'd5, 32'd5}, 32'd2, 32'd1, 32'd5, 1'b0);
        vecs[10] = mk(1'b0, 2'd1, 32'd8, 32'd5, {32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, {32'd5, 32'd5, 32'd5, 32'd5, 32'd5}, 32'd3, 32'd1, 32'd6, 1'b0);
        vecs[11] = mk(1'b0, 2'd1, 32'd9, 32'd5, {32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, {32'd5, 32'd5, 32'd5, 32'd5, 32'd5}, 32'd3, 32'd0, 32'd7, 1'b1);
        vecs[12] = mk(1'b1, 2'd0, 32'd9, 32'd9, {E, E, E, 32'd5, 32'd5}, {E, E, E, 32'd5, 32'd4}, 32'd0, 32'd0, 32'd4, 1'b0);
        vecs[13] = mk(1'b0, 2'd3, 32'd9, 32'd9, {E, E, E, 32'd5, 32'd4}, {E, E, E, 32'd4, 32'd4}, 32'd0, 32'd0, 32'd4, 1'b0);
        vecs[14] = mk(1'b0, 2'd3, 32'd9, 32'd9, {E, E, E, 32'd4, 32'd3}, {E, E, E, 32'd4, 32'd4}, 32'd0, 32'd0, 32'd4, 1'b0);
        vecs[15] = mk(1'b0, 2'd3, 32'd9, 32'd9, {E, E, E, 32'd3, 32'd2}, {E, E, E, 32'd4, 32'd4}, 32'd0, 32'd0, 32'd4, 1'b0);
        vecs[16] = mk(1'b0, 2'd3, 32'd9, 32'd9, {E, E, E, 32'd2, 32'd1}, {E, E, E, 32'd4, 32'd4}, 32'd0, 32'd0, 32'd4, 1'b0);
        vecs[17] = mk(1'b0, 2'd3, 32'd9, 32'd9, {E, E, E, 32'd1, 32'd0}, {E, E, E, 32'd4, 32'd4}, 32'd0, 32'd0, 32'd4, 1'b0);
        vecs[18] = mk(1'b0, 2'd3, 32'd9, 32'd9, {E, E, E, 32'd1, 32'd0}, {E, E, E, 32'd4, 32'd4}, 32'd0, 32'd0, 32'd1, 1'b1);
        vecs[19] = mk(1'b0, 2'd3, 32'd9, 32'd9, {E, E, E, 32'd1, 32'd0}, {E, E, E, 32'd4, 32'd4}, 32'd0, 32'd0, 32'd1, 1'b1);

        // Reset state.
        apply_reset();
        chk("rst slot0 x", slot_x(0), 32'd5);
        chk("rst slot0 y", slot_y(0), 32'd5);
        chk("rst slot1 x", slot_x(1), 32'd4);
        chk("rst slot1 y", slot_y(1), 32'd5);
        for (int k = 2; k < NSLOT; k++) begin
            chk($sformatf("rst slot%0d x", k), slot_x(k), E);
            chk($sformatf("rst slot%0d y", k), slot_y(k), E);
        end
        chk("rst score", score, 32'd0);
        chk("rst ate", 32'(ate), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst game_done", 32'(game_done), 32'd0);
        chk("rst state", 32'(fsm_state), 32'(ST_IDLE));

        for (int i = 0; i < NV; i++) run_vec(i);

        // Tick while busy is dropped: one move only, direction unchanged.
        apply_reset();
        pulse_tick(2'd1, 32'd9, 32'd9);
        chk("busy in scan", 32'(busy), 32'd1);
        tick = 1'b1;
        dir  = 2'd2;
        @(negedge clk);
        tick = 1'b0;
        edges = 2;
        ate_cnt = 0;
        while (busy && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        chk("drop edges", 32'(edges), 32'd4);
        repeat (4) @(negedge clk);
        chk("drop slot0 x", slot_x(0), 32'd6);
        chk("drop slot0 y", slot_y(0), 32'd5);
        chk("drop slot1 x", slot_x(1), 32'd5);
        chk("drop busy", 32'(busy), 32'd0);
        // Left is a reversal only if the direction is still right.
        pulse_tick(2'd3, 32'd9, 32'd9);
        wait_idle(edges, ate_cnt);
        chk("drop next x", slot_x(0), 32'd7);
        chk("drop next y", slot_y(0), 32'd5);

        // Reset during SCAN: no residual move, no ate.
        apply_reset();
        pulse_tick(2'd1, 32'd6, 32'd5);
        chk("mid state scan", 32'(fsm_state), 32'(ST_SCAN));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid slot0 x", slot_x(0), 32'd5);
        chk("mid slot1 x", slot_x(1), 32'd4);
        chk("mid slot2 x", slot_x(2), E);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid state", 32'(fsm_state), 32'(ST_IDLE));
        ate_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ate_cnt += int'(ate);
        end
        chk("mid ate", 32'(ate_cnt), 32'd0);
        chk("mid later slot0 x", slot_x(0), 32'd5);
        chk("mid later slot2 x", slot_x(2), E);
        chk("mid score", score, 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
